// File: rtl/queue_sched_pkg.sv
// queue_sched_pkg: shared state encoding, defaults and id-width helper for the queue scheduler
package queue_sched_pkg;
  typedef enum logic [2:0] {IDLE, FILL, PAD, SETTLE, HOLD} state_t;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam logic [7:0] DEF_PAD_BYTE = 8'h00;
  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/queue_sched_if.sv
// queue_sched_if: producer byte ports, queue write port and word handshake of the scheduler
interface queue_sched_if import queue_sched_pkg::*; #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] REQ_VALID, REQ_READY, REQ_LAST;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic Q_EN, WORD_VALID, WORD_READY, BUSY;
  logic [7:0] Q_DATA;
  logic [id_w(N_REQ)-1:0] WORD_SRC;
  modport master (
    input REQ_VALID, REQ_DATA, REQ_LAST, WORD_READY,
    output REQ_READY, Q_EN, Q_DATA, WORD_VALID, WORD_SRC, BUSY
  );
  modport slave (
    output REQ_VALID, REQ_DATA, REQ_LAST, WORD_READY,
    input REQ_READY, Q_EN, Q_DATA, WORD_VALID, WORD_SRC, BUSY
  );
endinterface

// File: rtl/queue_sched_rr_arbiter.sv
// rr_arbiter: picks the first set request at or above ptr, wrapping past N_REQ-1
module rr_arbiter import queue_sched_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IW = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt_id,
  output logic             gnt_any
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt_id = '0;
    idx = '0;
    gnt_any = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      gnt_id = req[idx] ? idx : gnt_id;
    end
  end
endmodule

// File: rtl/queue_sched.sv
// queue_sched: round-robin packer of requester bytes into padded queue words with a word handshake
module queue_sched import queue_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter logic [7:0] PAD_BYTE = DEF_PAD_BYTE
) (
  input logic CLK,
  input logic RST,
  queue_sched_if.master bus
);
  localparam int IW = id_w(N_REQ);
  localparam int CW = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES_PER_WORD - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] src_q, src_d, ptr_q, ptr_d, gnt_id;
  logic [7:0] q_data_q, q_data_d, sel_data;
  logic q_en_q, q_en_d, word_valid_q, word_valid_d, gnt_any, sel_valid, sel_last;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(bus.REQ_VALID),
    .ptr(ptr_q),
    .gnt_id(gnt_id),
    .gnt_any(gnt_any)
  );
  assign sel_valid = bus.REQ_VALID[src_q];
  assign sel_last = bus.REQ_LAST[src_q];
  assign sel_data = bus.REQ_DATA[{src_q, 3'b000} +: 8];
  assign bus.REQ_READY = state_q == FILL ? N_REQ'(1) << src_q : '0;
  assign bus.Q_EN = q_en_q;
  assign bus.Q_DATA = q_data_q;
  assign bus.WORD_VALID = word_valid_q;
  assign bus.WORD_SRC = src_q;
  assign bus.BUSY = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_d = src_q;
    ptr_d = ptr_q;
    q_en_d = 1'b0;
    q_data_d = q_data_q;
    word_valid_d = word_valid_q;
    case (state_q)
      IDLE: begin
        src_d = gnt_any ? gnt_id : src_q;
        cnt_d = gnt_any ? '0 : cnt_q;
        state_d = gnt_any ? FILL : IDLE;
      end
      FILL: begin
        q_en_d = sel_valid;
        q_data_d = sel_valid ? sel_data : q_data_q;
        cnt_d = sel_valid ? cnt_q + CW'(1) : cnt_q;
        state_d = !sel_valid ? FILL : cnt_q == LAST_CNT ? SETTLE : sel_last ? PAD : FILL;
      end
      PAD: begin
        q_en_d = 1'b1;
        q_data_d = PAD_BYTE;
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == LAST_CNT ? SETTLE : PAD;
      end
      SETTLE: begin
        state_d = q_en_q ? SETTLE : HOLD;
        word_valid_d = !q_en_q;
      end
      HOLD: begin
        word_valid_d = !bus.WORD_READY;
        ptr_d = !bus.WORD_READY ? ptr_q : src_q == IW'(N_REQ - 1) ? '0 : src_q + IW'(1);
        state_d = bus.WORD_READY ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      src_q <= '0;
      ptr_q <= '0;
      q_en_q <= 1'b0;
      q_data_q <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
      q_en_q <= q_en_d;
      q_data_q <= q_data_d;
      word_valid_q <= word_valid_d;
    end
  end
endmodule

// File: doc/queue_sched.md
Name: queue_sched

Overview:
- Round-robin scheduler that shares the byte-wide `queue` block between N_REQ byte producers.
- Grants the queue to one requester for a whole word (BYTES_PER_WORD bytes) and drives the queue's EN/DATA inputs.
- Pads short packets with zero bytes.
- Raises a word-valid handshake toward the consumer of the queue's 32-bit output once the word is complete.
- Sits between the producer ports and the `queue` instance in the datapath top.

Parameters:
- N_REQ, 4, number of byte requesters (2..8).
- BYTES_PER_WORD, 4, bytes packed per queue word.
- PAD_BYTE, 8'h00, byte value written for padding.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- REQ_VALID  input  N_REQ  per-requester byte valid.
- REQ_DATA  input  8*N_REQ  per-requester byte; requester i occupies [8i+7:8i].
- REQ_LAST  input  N_REQ  marks the final byte of a requester's packet.
- REQ_READY  output  N_REQ  byte accepted when VALID&READY at a rising edge.
- Q_EN  output  1  write strobe to queue EN.
- Q_DATA  output  8  byte to queue DATA.
- WORD_VALID  output  1  queue holds a complete word.
- WORD_READY  input  1  consumer has taken the word.
- WORD_SRC  output  $clog2(N_REQ)  requester id owning the current word.
- BUSY  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; Q_EN=0, Q_DATA=0, WORD_VALID=0, WORD_SRC=0, REQ_READY=0, BUSY=0.
  - Byte counter=0; RR pointer=0.
  - Any partial word is discarded.
- States: IDLE, FILL, PAD, SETTLE, HOLD.
- IDLE:
  - If any REQ_VALID is set, grant the first valid requester searching from the RR pointer upward with wrap.
  - Latch the grant into WORD_SRC, set cnt=0, go to FILL.
  - The grant is registered, so FILL starts the next cycle.
- FILL:
  - REQ_READY[WORD_SRC] = 1 (combinational from state); all other READY bits are 0.
  - On each accepted byte: Q_EN<=1, Q_DATA<=byte (registered, one-cycle latency to the queue), cnt<=cnt+1.
  - If the requester holds VALID low: stall, Q_EN<=0, grant held; there is no timeout.
  - Accepted byte with cnt==BYTES_PER_WORD-1 → SETTLE. This takes priority over REQ_LAST.
  - Accepted byte with REQ_LAST=1 and cnt<BYTES_PER_WORD-1 → PAD.
- PAD:
  - Each cycle: Q_EN<=1, Q_DATA<=PAD_BYTE, cnt<=cnt+1.
  - On the write with cnt==BYTES_PER_WORD-1 → SETTLE.
  - REQ_READY is all 0.
- SETTLE:
  - One cycle, Q_EN<=0, so that the queue's final capture lands.
  - Then go to HOLD with WORD_VALID<=1.
- HOLD:
  - WORD_VALID=1 until WORD_READY is sampled 1.
  - On that edge: WORD_VALID<=0, RR pointer<=WORD_SRC+1 (mod N_REQ), go to IDLE.
- Latency: final byte accepted at edge k → Q_EN high in cycle k+1 → WORD_VALID high from cycle k+3.
- WORD_READY high on the first HOLD cycle gives a one-cycle handshake; at least one IDLE cycle separates consecutive words.
- WORD_READY outside HOLD is ignored.
- Requesters that are valid but not granted wait; REQ_DATA is never sampled for them.
- REQ_LAST with a full count gives no padding.
- cnt width is $clog2(BYTES_PER_WORD)+1 and cnt is never compared beyond BYTES_PER_WORD-1.
- Byte-lane placement within Data_Q is owned by the queue. The scheduler delivers bytes strictly in acceptance order, pad bytes last.

Decomposition:
- queue_sched_pkg holds:
  - the state enum (IDLE, FILL, PAD, SETTLE, HOLD);
  - the default BYTES_PER_WORD;
  - the default PAD_BYTE;
  - the requester-id width function.
- One sub-module, rr_arbiter: combinational, with inputs req[N_REQ] and ptr, and outputs gnt_id and gnt_any. It is instanced once and used in IDLE.

Test Plan:
- Reset mid-FILL:
  - Stimulus: requester 1 sends 2 bytes, then RST pulses asynchronously between edges.
  - Response: all outputs 0 immediately; no WORD_VALID; the next grant follows priority from 0.
- Single full word:
  - Stimulus: requester 2 sends A1,A2,A3,A4 back-to-back.
  - Response: Q_EN is 4 consecutive cycles with Q_DATA A1..A4; WORD_VALID 3 cycles after A4 is accepted; WORD_SRC=2.
- Short packet:
  - Stimulus: requester 0 sends 5C with REQ_LAST=1.
  - Response: Q_DATA sequence 5C,00,00,00; WORD_VALID asserted; REQ_READY[0]=0 during PAD.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid, WORD_READY=1.
  - Response: WORD_SRC sequence 0,1,2,3,0; no byte from a non-granted requester ever appears on Q_DATA.
- Backpressure and stall:
  - Stimulus: WORD_READY held 0 for 10 cycles in HOLD, and the granted requester drops VALID for 3 cycles mid-word.
  - Response: WORD_VALID stays 1 with other requesters' READY=0; Q_EN=0 during the stall and the grant is kept; the word completes with the correct 4 bytes.
